block_a_atom_select: RTL and testbench
======================================

Name: block_a_atom_select

Overview:
- Upstream stage of block_b_mgs in the OMP datapath.
- Correlates the current residual with every column of Phi and picks the non-excluded column with the largest |correlation|.
- Presents that column's index as `lambda` and pulses `done_a`. The controller then forwards `lambda` to `start_b`.
- Keeps a 64-bit selected-atom mask, so no column is picked twice within one recovery.

Parameters:
- N_ATOMS, 64, number of Phi columns; fixes the lambda width at 6.
- DW, 24, signed lane width, Q11.13 (0x002000 = 1.0).
- LANES, 4, lanes per 96-bit BRAM word.
- FRAC, 13, fractional bits; products are shifted right by this amount.
- ACC_W, 40, accumulator and correlation width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start_a  in  1  one-cycle start pulse.
- current_i  in  5  iteration index; 0 clears the selected-atom mask at start.
- M_limit  in  3  words per column minus 1 (W = M_limit+1; 7 = 32 measurements).
- corr_thresh  in  40  stop threshold, unsigned; used only with the optional feature.
- phi_addr  out  9  Phi BRAM address {col[5:0], word[2:0]}.
- phi_data  in  96  Phi BRAM read data, 1-cycle latency, lane 0 = bits [23:0].
- res_addr  out  3  residual BRAM word address.
- res_data  in  96  residual BRAM read data, 1-cycle latency.
- lambda  out  6  selected column, held until the next done_a.
- max_corr  out  40  |correlation| of the selected column, unsigned.
- busy_a  out  1  high from start acceptance through done_a.
- done_a  out  1  one-cycle completion pulse.
- stop_a  out  1  stop indication, qualified by done_a.

Behaviour:
- Reset (asynchronous, any time, including mid-scan):
  - All outputs go to 0 and the FSM goes to IDLE.
  - The accumulator and the selected-atom mask are cleared.
  - The in-flight scan is abandoned with no done_a.
- FSM: IDLE -> SCAN -> DRAIN -> COMMIT -> IDLE.
- IDLE:
  - start_a=1 captures M_limit and current_i and sets busy_a.
  - If current_i==0, the mask is cleared in the same cycle.
  - Moves to SCAN.
- Start while busy: start_a is ignored while busy_a=1.
- SCAN:
  - Issues one read per cycle: col = 0..63, word = 0..M_limit inner loop, for 64*W cycles.
  - phi_addr = {col, word} and res_addr = word, issued in the same cycle.
  - Addresses are registered outputs.
- Pipeline, per returned word pair:
  - Stage 1: four signed 24x24 products (48 bits each), each arithmetic-shifted right by FRAC.
  - Stage 2: the four lanes are summed and added into the 40-bit accumulator. The accumulator restarts at word 0 of each column.
- Column end:
  - abs(acc) is formed; -2^39 saturates to 2^39-1.
  - The candidate wins only if its column is not masked and abs is strictly greater than the running max.
  - The running max starts at a "none" flag, so the first unmasked column always wins, even when abs is 0.
- Ties resolve to the lowest column index.
- DRAIN: waits for the pipeline to empty.
- COMMIT:
  - Registers lambda and max_corr.
  - Sets mask[lambda] unless stopping.
  - Pulses done_a for one cycle and drops busy_a on the same edge.
- Latency: done_a rises exactly 64*W+4 cycles after the start_a edge (516 for M_limit=7, 68 for M_limit=0).
- Overflow: the accumulator wraps at 40 bits. Its range is ample for |values| < 2^10 over 32 terms; no saturation is applied inside accumulation.
- phi_addr and res_addr hold their last value in IDLE.

Optional Feature:
- ATOM_A_THRESH_EN defined:
  - At COMMIT, if max_corr < corr_thresh, stop_a=1 with done_a and the mask is not updated.
  - lambda and max_corr are still reported.
- ATOM_A_THRESH_EN undefined:
  - stop_a is constant 0 and corr_thresh is unused.
  - The mask is always updated at COMMIT.

Test Plan:
- Basic pick:
  - Stimulus: M_limit=7, current_i=0; residual lanes all 0x002000; Phi column 17 lanes 0x002000, every other column 0x001000.
  - Response: done_a at +516 cycles, lambda=17, max_corr=0x0000040000, stop_a=0.
- Ties and exclusion:
  - Stimulus: all Phi lanes 0x001000; run current_i=0, then current_i=1, then current_i=2.
  - Response: lambda = 0, then 1, then 2.
  - Then restart with current_i=0: lambda=0 again, because the mask is cleared.
- Negative correlation:
  - Stimulus: column 5 lanes 0xFFE000 (-1.0), others 0x001000, residual 1.0.
  - Response: lambda=5, max_corr=0x40000.
- Short frame:
  - Stimulus: M_limit=0.
  - Response: phi_addr steps {col,3'b000} for col 0..63, res_addr stays 0, done_a at +68 cycles.
- Robustness:
  - Stimulus: start_a pulsed at cycle 100 of a scan.
  - Response: it is ignored and done_a still arrives at +516 from the first start.
  - Stimulus: rst pulsed at cycle 200.
  - Response: busy_a=0 and lambda=0 immediately, no done_a; the next start behaves as a fresh run.
- Threshold (ATOM_A_THRESH_EN only):
  - Stimulus: corr_thresh=0x40001 with the basic-pick data.
  - Response: stop_a=1 and lambda=17.
  - A following run with current_i=1 and corr_thresh=0 still returns lambda=17, because the mask was not updated.

Source files
------------

// File: rtl/block_a_atom_select.sv
// -----------------------------------------------------------------------------
// block_a_atom_select
//
// Atom-selection stage of the OMP datapath. On start_a it correlates the
// residual with every Phi column and reports the column with the largest
// |correlation| that has not already been picked in this recovery.
//
// Scan order: col 0..N_ATOMS-1 (outer), word 0..M_limit (inner), one BRAM read
// per cycle. Per returned word pair: stage 1 forms four Q-format products,
// stage 2 accumulates them, and a compare stage updates the running maximum.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start_a               one-cycle start pulse (ignored while busy_a)
//   current_i             iteration index; 0 clears the selected-atom mask
//   M_limit               words per column minus one
//   corr_thresh           stop threshold (used only with ATOM_A_THRESH_EN)
//   phi_addr / phi_data   Phi BRAM {col, word} address and 1-cycle read data
//   res_addr / res_data   residual BRAM word address and 1-cycle read data
//   lambda, max_corr      selected column and its |correlation|
//   busy_a, done_a        busy flag and one-cycle completion pulse
//   stop_a                stop indication, valid with done_a
//
// Optional feature macro: ATOM_A_THRESH_EN
//   defined   : stop_a = (max_corr < corr_thresh) at commit; the mask is not
//               updated when stopping.
//   undefined : stop_a is constant 0 and the mask is always updated.
// -----------------------------------------------------------------------------
module block_a_atom_select #(
  parameter int N_ATOMS = 64,
  parameter int DW      = 24,
  parameter int LANES   = 4,
  parameter int FRAC    = 13,
  parameter int ACC_W   = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_a,
  input  logic [4:0]             current_i,
  input  logic [2:0]             M_limit,
  input  logic [ACC_W-1:0]       corr_thresh,
  output logic [8:0]             phi_addr,
  input  logic [LANES*DW-1:0]    phi_data,
  output logic [2:0]             res_addr,
  input  logic [LANES*DW-1:0]    res_data,
  output logic [5:0]             lambda,
  output logic [ACC_W-1:0]       max_corr,
  output logic                   busy_a,
  output logic                   done_a,
  output logic                   stop_a
);

  localparam int IDX_W = 6;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_COMMIT} state_t;
  state_t state_q, state_d;

  // Scan counters hold the next address to issue.
  logic [IDX_W-1:0] col_q;
  logic [2:0]       word_q;
  logic [2:0]       m_q;

  // Control from the output process.
  logic             issue_en, start_acc, commit;
  logic [IDX_W-1:0] iss_col;
  logic [2:0]       iss_word, iss_m;
  logic             iss_word_last, last_issue;

  // Pipeline tags: issue -> read data -> products -> accumulator.
  logic             iss_v_q, rd_v_q, prod_v_q, acc_v_q;
  logic [IDX_W-1:0] iss_col_q, rd_col_q, prod_col_q, acc_col_q;
  logic             iss_first_q, rd_first_q, prod_first_q;
  logic             iss_last_q, rd_last_q, prod_last_q, acc_last_q;

  logic signed [ACC_W-1:0] prod_q [LANES];
  logic signed [ACC_W-1:0] prod_d [LANES];
  logic signed [ACC_W-1:0] lane_sum;
  logic signed [ACC_W-1:0] acc_q;

  logic [N_ATOMS-1:0] mask_q;
  logic               best_none_q;
  logic [IDX_W-1:0]   best_col_q;
  logic [ACC_W-1:0]   best_abs_q;
  logic [ACC_W-1:0]   acc_abs;
  logic               cand_win;
  logic               stop_now;

  logic [8:0]       phi_addr_q;
  logic [2:0]       res_addr_q;
  logic [IDX_W-1:0] lambda_q;
  logic [ACC_W-1:0] max_corr_q;
  logic             busy_q, done_q, stop_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_a) state_d = S_SCAN;
      S_SCAN:   if (last_issue) state_d = S_DRAIN;
      // The accumulator stage is consumed on the same edge that leaves DRAIN.
      S_DRAIN:  if (!iss_v_q && !rd_v_q && !prod_v_q) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // The first read is issued on the accepting edge so the scan does not lose a
  // cycle; it always addresses {0, 0} with the freshly presented M_limit.
  always_comb begin
    issue_en  = 1'b0;
    start_acc = 1'b0;
    commit    = 1'b0;
    iss_col   = col_q;
    iss_word  = word_q;
    iss_m     = m_q;
    case (state_q)
      S_IDLE: if (start_a) begin
        issue_en  = 1'b1;
        start_acc = 1'b1;
        iss_col   = '0;
        iss_word  = '0;
        iss_m     = M_limit;
      end
      S_SCAN:   issue_en = 1'b1;
      S_COMMIT: commit   = 1'b1;
      default: ;
    endcase
  end

  assign iss_word_last = (iss_word == iss_m);
  assign last_issue    = issue_en && iss_word_last && (iss_col == IDX_W'(N_ATOMS - 1));

  // ---------------- Address generation ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      word_q     <= '0;
      m_q        <= '0;
      phi_addr_q <= '0;
      res_addr_q <= '0;
    end else begin
      if (start_acc) m_q <= M_limit;
      if (issue_en) begin
        phi_addr_q <= {iss_col, iss_word};
        res_addr_q <= iss_word;
        if (iss_word_last) begin
          word_q <= '0;
          col_q  <= iss_col + 1'b1;
        end else begin
          word_q <= iss_word + 1'b1;
          col_q  <= iss_col;
        end
      end
    end
  end

  // ---------------- Stage 1: lane products ----------------
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DW-1:0]   phi_lane, res_lane;
      logic signed [2*DW-1:0] full_prod;
      assign phi_lane    = phi_data[gi*DW +: DW];
      assign res_lane    = res_data[gi*DW +: DW];
      assign full_prod   = phi_lane * res_lane;
      assign prod_d[gi]  = ACC_W'(full_prod >>> FRAC);
    end
  endgenerate

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + prod_q[i];
  end

  // ---------------- Pipeline ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_v_q  <= 1'b0; rd_v_q  <= 1'b0; prod_v_q <= 1'b0; acc_v_q <= 1'b0;
      iss_col_q <= '0; rd_col_q <= '0; prod_col_q <= '0; acc_col_q <= '0;
      iss_first_q <= 1'b0; rd_first_q <= 1'b0; prod_first_q <= 1'b0;
      iss_last_q  <= 1'b0; rd_last_q  <= 1'b0; prod_last_q  <= 1'b0; acc_last_q <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      acc_q <= '0;
    end else begin
      iss_v_q     <= issue_en;
      iss_col_q   <= iss_col;
      iss_first_q <= (iss_word == 3'd0);
      iss_last_q  <= iss_word_last;

      rd_v_q     <= iss_v_q;
      rd_col_q   <= iss_col_q;
      rd_first_q <= iss_first_q;
      rd_last_q  <= iss_last_q;

      prod_v_q <= rd_v_q;
      if (rd_v_q) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
        prod_col_q   <= rd_col_q;
        prod_first_q <= rd_first_q;
        prod_last_q  <= rd_last_q;
      end

      acc_v_q <= prod_v_q;
      if (prod_v_q) begin
        acc_q      <= (prod_first_q ? '0 : acc_q) + lane_sum;
        acc_col_q  <= prod_col_q;
        acc_last_q <= prod_last_q;
      end
    end
  end

  // ---------------- Column-end compare ----------------
  // The most negative value has no positive twin; clamp it.
  always_comb begin
    if (acc_q == {1'b1, {(ACC_W-1){1'b0}}})
      acc_abs = {1'b0, {(ACC_W-1){1'b1}}};
    else if (acc_q[ACC_W-1])
      acc_abs = $unsigned(-acc_q);
    else
      acc_abs = $unsigned(acc_q);
  end

  // Strict '>' keeps the lowest index on ties.
  assign cand_win = acc_v_q && acc_last_q && !mask_q[acc_col_q] &&
                    (best_none_q || (acc_abs > best_abs_q));

`ifdef ATOM_A_THRESH_EN
  assign stop_now = (best_abs_q < corr_thresh);
`else
  logic unused_thresh;
  assign unused_thresh = ^corr_thresh;
  assign stop_now      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_none_q <= 1'b1;
      best_col_q  <= '0;
      best_abs_q  <= '0;
      mask_q      <= '0;
    end else begin
      if (start_acc) begin
        best_none_q <= 1'b1;
        best_col_q  <= '0;
        best_abs_q  <= '0;
        if (current_i == 5'd0) mask_q <= '0;
      end else if (cand_win) begin
        best_none_q <= 1'b0;
        best_col_q  <= acc_col_q;
        best_abs_q  <= acc_abs;
      end
      if (commit && !stop_now) mask_q[best_col_q] <= 1'b1;
    end
  end

  // ---------------- Result registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lambda_q   <= '0;
      max_corr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      done_q <= commit;
      stop_q <= commit && stop_now;
      if (start_acc)   busy_q <= 1'b1;
      else if (commit) busy_q <= 1'b0;
      if (commit) begin
        lambda_q   <= best_col_q;
        max_corr_q <= best_abs_q;
      end
    end
  end

  assign phi_addr = phi_addr_q;
  assign res_addr = res_addr_q;
  assign lambda   = lambda_q;
  assign max_corr = max_corr_q;
  assign busy_a   = busy_q;
  assign done_a   = done_q;
  assign stop_a   = stop_q;

endmodule

// File: tb/tb_block_a_atom_select.sv
// Scoreboard bench for block_a_atom_select: stimulus pushes expected results,
// a monitor pops and checks them whenever done_a is presented.
module tb_block_a_atom_select;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic [4:0]  current_i = '0;
  logic [2:0]  M_limit = '0;
  logic [39:0] corr_thresh = '0;
  logic [8:0]  phi_addr;
  logic [95:0] phi_data;
  logic [2:0]  res_addr;
  logic [95:0] res_data;
  logic [5:0]  lambda;
  logic [39:0] max_corr;
  logic        busy_a, done_a, stop_a;

  block_a_atom_select dut (
    .clk(clk), .rst(rst), .start_a(start_a), .current_i(current_i),
    .M_limit(M_limit), .corr_thresh(corr_thresh),
    .phi_addr(phi_addr), .phi_data(phi_data),
    .res_addr(res_addr), .res_data(res_data),
    .lambda(lambda), .max_corr(max_corr),
    .busy_a(busy_a), .done_a(done_a), .stop_a(stop_a)
  );

  always #5 clk = ~clk;

  // BRAM models, one-cycle read latency.
  logic [95:0] phi_mem [0:511];
  logic [95:0] res_mem [0:7];
  always @(posedge clk) begin
    phi_data <= phi_mem[phi_addr];
    res_data <= res_mem[res_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  lam;
    logic [39:0] corr;
    logic        stop;
    int          start_cyc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  // Monitor: one transaction line per done_a.
  always @(negedge clk) begin
    if (done_a) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=lambda 0x%0h required=no done_a", lambda);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("lambda", 64'(lambda), 64'(e.lam));
        check("max_corr", 64'(max_corr), 64'(e.corr));
        check("stop_a", 64'(stop_a), 64'(e.stop));
        check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
      end
    end
  end

  task automatic load_phi(input int special, input logic [23:0] sval, input logic [23:0] oval);
    for (int i = 0; i < 512; i++)
      phi_mem[i] = ((i / 8) == special) ? {4{sval}} : {4{oval}};
  endtask

  task automatic start_run(input logic [2:0] m, input logic [4:0] cur,
                           input logic [39:0] thr, output int sc);
    @(negedge clk);
    M_limit = m;
    current_i = cur;
    corr_thresh = thr;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    sc = cyc;
  endtask

  task automatic expect_result(input int sc, input logic [5:0] lam, input logic [39:0] corr,
                               input logic stop, input int lat);
    exp_t e;
    e.lam = lam; e.corr = corr; e.stop = stop; e.start_cyc = sc; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_a && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy_a) begin
      checks++;
      failures++;
      $display("FAIL run_timeout actual=busy_a 1 after %0d cycles required=busy_a 0", n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic [2:0] m, input logic [4:0] cur, input logic [39:0] thr,
                     input logic [5:0] lam, input logic [39:0] corr, input logic stop,
                     input int lat);
    int sc;
    start_run(m, cur, thr, sc);
    expect_result(sc, lam, corr, stop, lat);
    check("busy_after_start", 64'(busy_a), 64'd1);
    wait_idle();
  endtask

  initial begin
    int sc;
    int bad;
    int first_bad;

    for (int i = 0; i < 8; i++) res_mem[i] = {4{24'h002000}};
    load_phi(17, 24'h002000, 24'h001000);

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy_a), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", 64'(busy_a), 64'd0);
    check("idle_done", 64'(done_a), 64'd0);
    check("idle_lambda", 64'(lambda), 64'd0);
    check("idle_max_corr", 64'(max_corr), 64'd0);
    check("idle_phi_addr", 64'(phi_addr), 64'd0);

    // Basic pick.
    run(3'd7, 5'd0, 40'd0, 6'd17, 40'h40000, 1'b0, 516);

    // Ties and exclusion.
    load_phi(-1, 24'h001000, 24'h001000);
    run(3'd7, 5'd0, 40'd0, 6'd0, 40'h20000, 1'b0, 516);
    run(3'd7, 5'd1, 40'd0, 6'd1, 40'h20000, 1'b0, 516);
    run(3'd7, 5'd2, 40'd0, 6'd2, 40'h20000, 1'b0, 516);
    run(3'd7, 5'd0, 40'd0, 6'd0, 40'h20000, 1'b0, 516);

    // Negative correlation.
    load_phi(5, 24'hFFE000, 24'h001000);
    run(3'd7, 5'd0, 40'd0, 6'd5, 40'h40000, 1'b0, 516);

    // Short frame with address trace.
    load_phi(-1, 24'h001000, 24'h001000);
    start_run(3'd0, 5'd0, 40'd0, sc);
    expect_result(sc, 6'd0, 40'h4000, 1'b0, 68);
    bad = 0;
    first_bad = -1;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (phi_addr !== {6'(k), 3'b000} || res_addr !== 3'd0) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    check("short_addr_trace_bad_steps", 64'(bad), 64'd0);
    wait_idle();
    check("idle_hold_phi_addr", 64'(phi_addr), 64'h1F8);
    check("idle_hold_res_addr", 64'(res_addr), 64'd0);

    // Start while busy is ignored.
    load_phi(17, 24'h002000, 24'h001000);
    start_run(3'd7, 5'd0, 40'd0, sc);
    expect_result(sc, 6'd17, 40'h40000, 1'b0, 516);
    repeat (100) @(negedge clk);
    M_limit = 3'd0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    M_limit = 3'd7;
    wait_idle();

    // Reset mid-scan: no done_a, outputs cleared, mask cleared.
    start_run(3'd7, 5'd1, 40'd0, sc);
    repeat (200) @(negedge clk);
    check("pre_reset_lambda", 64'(lambda), 64'd17);
    #2;
    rst = 1'b1;
    #1;
    check("reset_mid_busy", 64'(busy_a), 64'd0);
    check("reset_mid_lambda", 64'(lambda), 64'd0);
    check("reset_mid_max_corr", 64'(max_corr), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (600) @(negedge clk);
    check("no_done_after_reset_busy", 64'(busy_a), 64'd0);
    run(3'd7, 5'd1, 40'd0, 6'd17, 40'h40000, 1'b0, 516);

`ifdef ATOM_A_THRESH_EN
    run(3'd7, 5'd0, 40'h40001, 6'd17, 40'h40000, 1'b1, 516);
    run(3'd7, 5'd1, 40'd0, 6'd17, 40'h40000, 1'b0, 516);
`endif

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
